// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue controller feeding uart_send over its DATA/DATA_READY/IDLE handshake.
// Writes that arrive while the FIFO is full are dropped and raise a sticky OVERFLOW flag.
module uart_tx_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVERFLOW,
  output logic [7:0]            TX_DATA,
  output logic                  TX_DATA_READY,
  input  logic                  TX_IDLE
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  logic [7:0]            mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  overflow_r;
  logic [7:0]            tx_data_r;
  logic                  tx_ready_r;
  state_t                state_r;

  state_t                state_s;
  logic [7:0]            tx_data_s;
  logic                  tx_ready_s;
  logic [ADDR_WIDTH:0]   count_s;
  logic                  wr_s;
  logic                  drop_s;
  logic                  pop_s;

  // FULL is the registered flag, so a pop in the same cycle never rescues a write.
  assign wr_s   = WR_EN & ~full_r;
  assign drop_s = WR_EN & full_r;
  assign pop_s  = (state_r == S_ISSUE) & TX_IDLE;

  // Issue FSM: next state and next values of the registered handshake outputs.
  always_comb begin
    state_s    = state_r;
    tx_data_s  = tx_data_r;
    tx_ready_s = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (!empty_r && TX_IDLE) begin
          tx_data_s  = mem_r[rd_ptr_r];
          tx_ready_s = 1'b1;
          state_s    = S_ISSUE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (TX_IDLE) begin
          tx_ready_s = 1'b0;
          state_s    = S_HOLD;
        end else begin
          tx_ready_s = 1'b1;
          state_s    = S_ISSUE;
        end
      end
      S_HOLD: begin
        state_s = S_WAIT;
      end
      default: begin
        state_s = S_WAIT;
      end
    endcase
  end

  // Occupancy update; a write and a pop in the same cycle cancel out.
  always_comb begin
    count_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_s = count_r + COUNT_ONE;
      2'b01:   count_s = count_r - COUNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= WR_DATA;
    end
  end

  // Pointers, occupancy flags, overflow flag and FSM registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
      count_r    <= COUNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_ready_r <= 1'b0;
      state_r    <= S_WAIT;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_s;
      full_r  <= (count_s == COUNT_MAX);
      empty_r <= (count_s == COUNT_ZERO);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (CLR_OVERFLOW) begin
        overflow_r <= 1'b0;
      end
      tx_data_r  <= tx_data_s;
      tx_ready_r <= tx_ready_s;
      state_r    <= state_s;
    end
  end

  assign FULL          = full_r;
  assign EMPTY         = empty_r;
  assign COUNT         = count_r;
  assign OVERFLOW      = overflow_r;
  assign TX_DATA       = tx_data_r;
  assign TX_DATA_READY = tx_ready_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a uart_send IDLE model and a byte scoreboard.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] WR_DATA;
  logic       WR_EN;
  logic       FULL;
  logic       EMPTY;
  logic [4:0] COUNT;
  logic       OVERFLOW;
  logic       CLR_OVERFLOW;
  logic [7:0] TX_DATA;
  logic       TX_DATA_READY;
  logic       TX_IDLE;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] sb[$];

  // uart_send model: samples on READY&IDLE, then IDLE low for busy_len cycles
  int         busy_len = 22;
  int         busy_cnt = 0;
  logic       uart_block = 1'b0;
  logic       got_valid = 1'b0;
  logic [7:0] got_byte = 8'h00;
  logic       prev_hit = 1'b0;
  logic [7:0] exp_b;

  uart_tx_fifo #(.ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
    .CLR_OVERFLOW(CLR_OVERFLOW), .TX_DATA(TX_DATA),
    .TX_DATA_READY(TX_DATA_READY), .TX_IDLE(TX_IDLE)
  );

  always #5 CLK = ~CLK;

  assign TX_IDLE = (busy_cnt == 0) && !uart_block;

  always @(posedge CLK) begin
    got_valid <= 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (TX_DATA_READY === 1'b1 && TX_IDLE) begin
      got_valid <= 1'b1;
      got_byte  <= TX_DATA;
      busy_cnt  <= busy_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every byte the model sampled, plus no-double-sample check
  always @(negedge CLK) begin
    if (got_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra observed=%0h expected=none", got_byte);
      end else begin
        exp_b = sb.pop_front();
        chk("tx_byte", {24'h0, got_byte}, {24'h0, exp_b});
      end
    end
    if (prev_hit) chk("no_double_sample", {31'h0, TX_DATA_READY}, 32'h0);
    prev_hit <= (TX_DATA_READY === 1'b1) && (TX_IDLE === 1'b1);
  end

  task automatic push(input logic [7:0] b, input bit accept);
    WR_DATA = b;
    WR_EN   = 1'b1;
    if (accept) sb.push_back(b);
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge CLK);
    chk("drain_timeout", sb.size(), 32'h0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !TX_IDLE; i++) @(negedge CLK);
    chk("idle_timeout", {31'h0, TX_IDLE}, 32'h1);
  endtask

  initial begin
    int p0;
    RST_N = 1'b0; WR_EN = 1'b1; WR_DATA = 8'h5A; CLR_OVERFLOW = 1'b0;

    // 1: reset held two cycles with WR_EN high
    repeat (2) begin
      @(negedge CLK);
      chk("rst_count", {27'h0, COUNT}, 32'h0);
      chk("rst_empty", {31'h0, EMPTY}, 32'h1);
      chk("rst_full", {31'h0, FULL}, 32'h0);
      chk("rst_ovf", {31'h0, OVERFLOW}, 32'h0);
      chk("rst_rdy", {31'h0, TX_DATA_READY}, 32'h0);
    end
    RST_N = 1'b1; WR_EN = 1'b0;
    @(negedge CLK);

    // 2: single byte latency
    WR_DATA = 8'hA5; WR_EN = 1'b1; sb.push_back(8'hA5);
    @(negedge CLK); WR_EN = 1'b0;
    chk("t2_empty_k", {31'h0, EMPTY}, 32'h0);
    chk("t2_count_k", {27'h0, COUNT}, 32'h1);
    chk("t2_rdy_k", {31'h0, TX_DATA_READY}, 32'h0);
    @(negedge CLK);
    chk("t2_rdy_k1", {31'h0, TX_DATA_READY}, 32'h1);
    chk("t2_data", {24'h0, TX_DATA}, 32'hA5);
    @(negedge CLK);
    chk("t2_rdy_k2", {31'h0, TX_DATA_READY}, 32'h0);
    chk("t2_count_k2", {27'h0, COUNT}, 32'h0);
    chk("t2_empty_k2", {31'h0, EMPTY}, 32'h1);
    wait_drain(50);

    // 3: burst of 16 against the slow serialiser
    wait_idle();
    p0 = pulses;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    wait_drain(1000);
    chk("t3_pulses", pulses - p0, 32'd16);
    chk("t3_count", {27'h0, COUNT}, 32'h0);

    // 4: overflow with serialiser stalled
    wait_idle();
    uart_block = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
    chk("t4_full", {31'h0, FULL}, 32'h1);
    chk("t4_count16", {27'h0, COUNT}, 32'd16);
    chk("t4_ovf_pre", {31'h0, OVERFLOW}, 32'h0);
    push(8'hEE, 1'b0);
    chk("t4_ovf_set", {31'h0, OVERFLOW}, 32'h1);
    chk("t4_count_drop", {27'h0, COUNT}, 32'd16);
    CLR_OVERFLOW = 1'b1;
    push(8'hEF, 1'b0);
    chk("t4_set_beats_clr", {31'h0, OVERFLOW}, 32'h1);
    @(negedge CLK); CLR_OVERFLOW = 1'b0;
    chk("t4_ovf_clr", {31'h0, OVERFLOW}, 32'h0);

    // 5b: full + pop + write -> write dropped
    uart_block = 1'b0;
    @(negedge CLK);
    chk("t5b_rdy", {31'h0, TX_DATA_READY}, 32'h1);
    chk("t5b_head", {24'h0, TX_DATA}, 32'h20);
    push(8'hDD, 1'b0);
    chk("t5b_count15", {27'h0, COUNT}, 32'd15);
    chk("t5b_full", {31'h0, FULL}, 32'h0);
    chk("t5b_ovf", {31'h0, OVERFLOW}, 32'h1);
    CLR_OVERFLOW = 1'b1;
    @(negedge CLK); CLR_OVERFLOW = 1'b0;
    wait_drain(1000);
    chk("t5b_count0", {27'h0, COUNT}, 32'h0);

    // 5a: COUNT=1 in S_ISSUE, write lands on the pop edge
    wait_idle();
    push(8'h61, 1'b1);
    @(negedge CLK);
    chk("t5a_rdy", {31'h0, TX_DATA_READY}, 32'h1);
    chk("t5a_count_pre", {27'h0, COUNT}, 32'h1);
    push(8'h62, 1'b1);
    chk("t5a_count_post", {27'h0, COUNT}, 32'h1);
    chk("t5a_rdy_post", {31'h0, TX_DATA_READY}, 32'h0);
    wait_drain(200);

    // 6: 40 bytes through, pointers wrap twice
    busy_len = 0;
    wait_idle();
    p0 = pulses;
    for (int i = 0; i < 40; i++) begin
      push(8'h80 + 8'(i), 1'b1);
      @(negedge CLK);
    end
    wait_drain(500);
    chk("t6_pulses", pulses - p0, 32'd40);
    chk("t6_count", {27'h0, COUNT}, 32'h0);

    // 6: reset while in S_ISSUE with COUNT=5
    uart_block = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
    uart_block = 1'b0;
    @(negedge CLK);
    uart_block = 1'b1;
    chk("t6_rdy_issue", {31'h0, TX_DATA_READY}, 32'h1);
    chk("t6_count5", {27'h0, COUNT}, 32'd5);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    sb.delete();
    chk("t6_rst_count", {27'h0, COUNT}, 32'h0);
    chk("t6_rst_rdy", {31'h0, TX_DATA_READY}, 32'h0);
    chk("t6_rst_empty", {31'h0, EMPTY}, 32'h1);
    uart_block = 1'b0;
    @(negedge CLK);
    chk("t6_rdy_after", {31'h0, TX_DATA_READY}, 32'h0);
    push(8'h3C, 1'b1);
    wait_drain(50);
    chk("t6_final_count", {27'h0, COUNT}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
